// File: rtl/user_data_chk.sv
// Aurora RX frame checker: validates header magic/sequence, payload ramp and length; counts frames/errors.
// Latency: error pulses and counter updates 1 cycle after the offending beat; never back-pressures (no tready).
module user_data_chk #(
    parameter int          P_FRAME_LEN   = 256,
    parameter logic [15:0] P_HDR_MAGIC   = 16'h55AA,
    parameter int          P_GOOD_FRAMES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_channel_up,
    input  logic [31:0] s_axi_rx_tdata,
    input  logic [3:0]  s_axi_rx_tkeep,
    input  logic        s_axi_rx_tlast,
    input  logic        s_axi_rx_tvalid,
    output logic [31:0] o_frame_cnt,
    output logic [15:0] o_err_cnt,
    output logic        o_data_err,
    output logic        o_seq_err,
    output logic        o_len_err,
    output logic        o_link_ok
);
    localparam int CW = $clog2(P_FRAME_LEN + 1);
    localparam int GW = $clog2(P_GOOD_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t         state, state_nxt;
    logic           first_frame;
    logic [15:0]    exp_seq;
    logic [CW-1:0]  beat_cnt;
    logic           data_flagged;
    logic           frame_bad;
    logic [GW-1:0]  good_cnt;
    logic           seq_e, data_e, len_e, frame_end;
    logic [1:0]     err_inc;
    logic [16:0]    err_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        seq_e     = 1'b0;
        data_e    = 1'b0;
        len_e     = 1'b0;
        frame_end = 1'b0;
        if (!i_channel_up) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = HEAD;
                HEAD: if (s_axi_rx_tvalid) begin
                    seq_e = (s_axi_rx_tdata[31:16] != P_HDR_MAGIC) ||
                            (!first_frame && s_axi_rx_tdata[15:0] != exp_seq);
                    if (s_axi_rx_tlast) len_e = 1'b1;
                    else                state_nxt = BODY;
                end
                BODY: if (s_axi_rx_tvalid) begin
                    // beat_cnt == P_FRAME_LEN marks "past the expected end": no payload check there
                    if (beat_cnt < CW'(P_FRAME_LEN))
                        data_e = !data_flagged &&
                                 (s_axi_rx_tdata != 32'(beat_cnt) - 32'd1 || s_axi_rx_tkeep != 4'hF);
                    if (s_axi_rx_tlast) begin
                        len_e     = (beat_cnt != CW'(P_FRAME_LEN - 1));
                        frame_end = 1'b1;
                        state_nxt = HEAD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        err_inc = 2'(seq_e) + 2'(data_e) + 2'(len_e);
        err_sum = {1'b0, o_err_cnt} + 17'(err_inc);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            first_frame  <= 1'b1;
            exp_seq      <= '0;
            beat_cnt     <= '0;
            data_flagged <= 1'b0;
            frame_bad    <= 1'b0;
            good_cnt     <= '0;
            o_frame_cnt  <= '0;
            o_err_cnt    <= '0;
            o_data_err   <= 1'b0;
            o_seq_err    <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            o_data_err <= data_e;
            o_seq_err  <= seq_e;
            o_len_err  <= len_e;
            o_err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (!i_channel_up) begin
                // partial frame is dropped silently; next header resynchronises the sequence
                first_frame  <= 1'b1;
                good_cnt     <= '0;
                beat_cnt     <= '0;
                data_flagged <= 1'b0;
                frame_bad    <= 1'b0;
            end else begin
                if (state == HEAD && s_axi_rx_tvalid) begin
                    exp_seq      <= s_axi_rx_tdata[15:0] + 16'd1;
                    first_frame  <= 1'b0;
                    data_flagged <= 1'b0;
                    frame_bad    <= seq_e;
                    beat_cnt     <= s_axi_rx_tlast ? CW'(0) : CW'(1);
                end else if (state == BODY && s_axi_rx_tvalid) begin
                    if (data_e) begin
                        data_flagged <= 1'b1;
                        frame_bad    <= 1'b1;
                    end
                    if (s_axi_rx_tlast)                     beat_cnt <= '0;
                    else if (beat_cnt != CW'(P_FRAME_LEN)) beat_cnt <= beat_cnt + 1'b1;
                end
                if (seq_e || data_e || len_e)
                    good_cnt <= '0;
                else if (frame_end && !frame_bad && good_cnt != GW'(P_GOOD_FRAMES))
                    good_cnt <= good_cnt + 1'b1;
                if (frame_end && !len_e && o_frame_cnt != 32'hFFFF_FFFF)
                    o_frame_cnt <= o_frame_cnt + 32'd1;
            end
        end
    end

    assign o_link_ok = (good_cnt >= GW'(P_GOOD_FRAMES));
endmodule

// File: tb/tb_user_data_chk.sv
// Directed bench for user_data_chk: clean run, payload/sequence/length errors, wrap, channel drop, async reset.
module tb_user_data_chk;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        channel_up = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        data_err, seq_err, len_err, link_ok;

    int checks = 0;
    int failures = 0;
    int n_data = 0, n_seq = 0, n_len = 0;

    user_data_chk dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_channel_up    (channel_up),
        .s_axi_rx_tdata  (tdata),
        .s_axi_rx_tkeep  (tkeep),
        .s_axi_rx_tlast  (tlast),
        .s_axi_rx_tvalid (tvalid),
        .o_frame_cnt     (frame_cnt),
        .o_err_cnt       (err_cnt),
        .o_data_err      (data_err),
        .o_seq_err       (seq_err),
        .o_len_err       (len_err),
        .o_link_ok       (link_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_err) n_data++;
        if (seq_err)  n_seq++;
        if (len_err)  n_len++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns at posedge+1; on return the last beat has just been captured.
    task automatic send_frame(input logic [15:0] seq, input logic [15:0] magic, input int len,
                              input int bad_beat, input int keep_beat, input bit no_tlast, input bit gap);
        for (int k = 0; k < len; k++) begin
            if (gap && k == 7) begin
                tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            tvalid = 1'b1;
            tkeep  = 4'hF;
            tdata  = (k == 0) ? {magic, seq} : 32'(k - 1);
            if (k == bad_beat)  tdata = 32'hDEAD_BEEF;
            if (k == keep_beat) tkeep = 4'h0;
            tlast  = !no_tlast && (k == len - 1);
            @(posedge clk);
            #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
    endtask

    task automatic good(input logic [15:0] seq);
        send_frame(seq, 16'h55AA, 256, -1, -1, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        idle(3);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_pulses", {29'd0, data_err, seq_err, len_err}, 32'd0);
        chk("rst_link_ok", 32'(link_ok), 32'd0);
        rst = 1'b0;
        channel_up = 1'b1;
        idle(2);

        // 20 clean frames, one with an idle gap mid-frame
        for (int i = 0; i < 20; i++) begin
            send_frame(16'(i), 16'h55AA, 256, -1, -1, 1'b0, i == 3);
            if (i == 14) chk("link_ok_after_15", 32'(link_ok), 32'd0);
            if (i == 15) chk("link_ok_after_16", 32'(link_ok), 32'd1);
        end
        idle(1);
        chk("t1_frame_cnt", frame_cnt, 32'd20);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);
        chk("t1_link_ok", 32'(link_ok), 32'd1);

        // payload word and tkeep corrupted in one frame -> one data pulse only
        send_frame(16'd20, 16'h55AA, 256, 10, 20, 1'b0, 1'b0);
        idle(1);
        chk("t2_data_pulses", 32'(n_data), 32'd1);
        chk("t2_err_cnt", 32'(err_cnt), 32'd1);
        chk("t2_frame_cnt", frame_cnt, 32'd21);
        chk("t2_link_ok", 32'(link_ok), 32'd0);

        // sequence skip then resync
        good(16'd21);
        good(16'd22);
        good(16'd24);
        good(16'd25);
        idle(1);
        chk("t3_seq_pulses", 32'(n_seq), 32'd1);
        chk("t3_err_cnt", 32'(err_cnt), 32'd2);
        chk("t3_frame_cnt", frame_cnt, 32'd25);

        // short frame: tlast on beat 100
        send_frame(16'd26, 16'h55AA, 101, -1, -1, 1'b0, 1'b0);
        chk("t4_len_pulse", 32'(len_err), 32'd1);
        idle(1);
        chk("t4_len_pulse_end", 32'(len_err), 32'd0);
        chk("t4_frame_cnt", frame_cnt, 32'd25);
        good(16'd27);
        idle(1);
        chk("t4_err_cnt", 32'(err_cnt), 32'd3);
        chk("t4_frame_cnt_next", frame_cnt, 32'd26);

        // channel drop at beat 50, then restart with arbitrary sequence
        send_frame(16'd28, 16'h55AA, 50, -1, -1, 1'b1, 1'b0);
        channel_up = 1'b0;
        idle(4);
        channel_up = 1'b1;
        idle(2);
        good(16'd7);
        good(16'd8);
        idle(1);
        chk("t6_err_cnt", 32'(err_cnt), 32'd3);
        chk("t6_frame_cnt", frame_cnt, 32'd28);
        chk("t6_link_ok", 32'(link_ok), 32'd0);

        // sequence wrap after a resync, then bad magic, then header-only frame
        channel_up = 1'b0;
        idle(2);
        channel_up = 1'b1;
        idle(2);
        good(16'hFFFE);
        good(16'hFFFF);
        good(16'h0000);
        idle(1);
        chk("t5_wrap_err_cnt", 32'(err_cnt), 32'd3);
        chk("t5_wrap_frame_cnt", frame_cnt, 32'd31);
        send_frame(16'h0001, 16'h55AB, 256, -1, -1, 1'b0, 1'b0);
        idle(1);
        chk("t5_magic_seq_pulses", 32'(n_seq), 32'd2);
        chk("t5_magic_err_cnt", 32'(err_cnt), 32'd4);
        chk("t5_magic_frame_cnt", frame_cnt, 32'd32);
        send_frame(16'h0002, 16'h55AA, 1, -1, -1, 1'b0, 1'b0);
        chk("t5_hdr_only_len", 32'(len_err), 32'd1);
        idle(1);
        chk("t5_hdr_only_err_cnt", 32'(err_cnt), 32'd5);
        chk("t5_hdr_only_frame_cnt", frame_cnt, 32'd32);
        chk("t5_data_pulses", 32'(n_data), 32'd1);

        // async reset mid-frame, checked before the next clock edge
        send_frame(16'h0003, 16'h55AA, 30, -1, -1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_frame_cnt", frame_cnt, 32'd0);
        chk("t6_arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("t6_arst_link_ok", 32'(link_ok), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        good(16'h1234);
        idle(1);
        chk("t6_post_rst_frame_cnt", frame_cnt, 32'd1);
        chk("t6_post_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("t6_len_pulses", 32'(n_len), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
